// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents: alu_func encodings (ALU_ADD..ALU_DIV) and the FSM state type.
// Used by alu_seq, alu_muldiv_iter and the testbench.
package alu_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [FUNC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [FUNC_W-1:0] ALU_AND = 3'b010;
  localparam logic [FUNC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [FUNC_W-1:0] ALU_XOR = 3'b100;
  localparam logic [FUNC_W-1:0] ALU_SLT = 3'b101;
  localparam logic [FUNC_W-1:0] ALU_MUL = 3'b110;
  localparam logic [FUNC_W-1:0] ALU_DIV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / divide engine, one iteration per clock, WIDTH iterations.
// The first iteration is performed on the start edge directly from a/b, so the
// result registers (q, r) and the done pulse land WIDTH-1 edges after start.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin an operation (operands sampled on this edge)
//   op         0 = MUL (unsigned shift-add), 1 = DIV (unsigned restoring)
//   a, b       operands (MUL: a*b, DIV: a/b)
//   done       one-cycle pulse, q/r valid from this cycle on
//   q          MUL: low WIDTH bits of product; DIV: quotient
//   r          DIV: remainder; 0 for MUL
// Macro ALU_DIV_EN: when undefined the divider path is not built and start is
// ignored for op=1.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [WIDTH-1:0] acc;   // MUL: partial product; DIV: partial remainder
  logic [WIDTH-1:0] sh;    // MUL: multiplier; DIV: dividend shifting out, quotient in
  logic [WIDTH-1:0] opnd;  // MUL: multiplicand; DIV: divisor

  logic             go;
  logic             div_src;
  logic [WIDTH-1:0] acc_src, sh_src, opnd_src;
  logic [WIDTH-1:0] acc_step, sh_step;

`ifdef ALU_DIV_EN
  logic             is_div;
  logic [WIDTH:0]   trial;
  assign go = start;
`else
  assign go = start & ~op;
`endif

  // One iteration, fed from fresh operands on the start edge, else from the registers
  always_comb begin
`ifdef ALU_DIV_EN
    div_src = go ? op : is_div;
`else
    div_src = 1'b0;
`endif
    acc_src  = go ? '0 : acc;
    sh_src   = go ? (div_src ? a : b) : sh;
    opnd_src = go ? (div_src ? b : a) : opnd;
    // MSB-first shift-add: acc = 2*acc + (multiplier bit ? multiplicand : 0)
    acc_step = {acc_src[WIDTH-2:0], 1'b0} + (sh_src[WIDTH-1] ? opnd_src : '0);
    sh_step  = {sh_src[WIDTH-2:0], 1'b0};
`ifdef ALU_DIV_EN
    // Restoring step: bring down next dividend bit, subtract divisor if it fits
    trial = {acc_src, sh_src[WIDTH-1]} - {1'b0, opnd_src};
    if (div_src) begin
      if (!trial[WIDTH]) begin
        acc_step = trial[WIDTH-1:0];
        sh_step  = {sh_src[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_src[WIDTH-2:0], sh_src[WIDTH-1]};
      end
    end
`endif
  end

  // Iteration state and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      acc  <= '0;
      sh   <= '0;
      opnd <= '0;
      q    <= '0;
      r    <= '0;
`ifdef ALU_DIV_EN
      is_div <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (go) begin
        acc  <= acc_step;
        sh   <= sh_step;
        opnd <= opnd_src;
        cnt  <= CNT_W'(WIDTH - 1);
        busy <= 1'b1;
`ifdef ALU_DIV_EN
        is_div <= op;
`endif
      end else if (busy) begin
        acc <= acc_step;
        sh  <= sh_step;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          q    <= div_src ? sh_step : acc_step;
          r    <= div_src ? acc_step : '0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake on input and output.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT) complete on the accept edge; MUL and
// DIV run on alu_muldiv_iter. Results are held until out_ready is sampled high.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, alu_func      operands and op select
//   out_valid/out_ready result handshake
//   data_out, rem_out   result / DIV remainder (0 for other ops)
//   div_zero, illegal   flags, valid with out_valid
// Macro ALU_DIV_EN: enables DIV; when undefined func 111 reports illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [FUNC_W-1:0] alu_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic [WIDTH-1:0]  rem_out,
  output logic              div_zero,
  output logic              illegal
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_nxt, rem_nxt;
  logic             dz_nxt, ill_nxt;
  logic             eng_start, eng_op, eng_done;
  logic [WIDTH-1:0] eng_q, eng_r;

  assign eng_op = (alu_func == ALU_DIV);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (eng_start),
    .op    (eng_op),
    .a     (a),
    .b     (b),
    .done  (eng_done),
    .q     (eng_q),
    .r     (eng_r)
  );

  // Next state, next result and engine launch
  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    rem_nxt   = rem_out;
    dz_nxt    = div_zero;
    ill_nxt   = illegal;
    eng_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = S_DONE;
          rem_nxt   = '0;
          dz_nxt    = 1'b0;
          ill_nxt   = 1'b0;
          case (alu_func)
            ALU_ADD: data_nxt = a + b;
            ALU_SUB: data_nxt = a - b;
            ALU_AND: data_nxt = a & b;
            ALU_OR:  data_nxt = a | b;
            ALU_XOR: data_nxt = a ^ b;
            ALU_SLT: data_nxt = WIDTH'($signed(a) < $signed(b));
            ALU_MUL: begin
              eng_start = 1'b1;
              state_nxt = S_BUSY;
            end
            default: begin  // ALU_DIV
`ifdef ALU_DIV_EN
              if (b == '0) begin
                data_nxt = '1;
                rem_nxt  = a;
                dz_nxt   = 1'b1;
              end else begin
                eng_start = 1'b1;
                state_nxt = S_BUSY;
              end
`else
              data_nxt = '0;
              ill_nxt  = 1'b1;
`endif
            end
          endcase
        end
      end
      S_BUSY: begin
        if (eng_done) begin
          state_nxt = S_DONE;
          data_nxt  = eng_q;
          rem_nxt   = eng_r;
        end
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; handshake flags track the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      rem_out   <= '0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
      data_out  <= data_nxt;
      rem_out   <= rem_nxt;
      div_zero  <= dz_nxt;
      illegal   <= ill_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned WIDTH = 32;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a, b;
  logic [FUNC_W-1:0] alu_func;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  data_out, rem_out;
  logic              div_zero, illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_func  (alu_func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .rem_out   (rem_out),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: results and latency straight from the op definitions
  task automatic ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] d, output logic [31:0] r,
                           output logic dz, output logic il, output int lat);
    d = 0; r = 0; dz = 0; il = 0; lat = 1;
    case (f)
      ALU_ADD: d = x + y;
      ALU_SUB: d = x - y;
      ALU_AND: d = x & y;
      ALU_OR:  d = x | y;
      ALU_XOR: d = x ^ y;
      ALU_SLT: d = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_MUL: begin d = x * y; lat = WIDTH + 1; end
      default: begin
        if (!DIV_EN) il = 1;
        else if (y == 0) begin d = 32'hFFFF_FFFF; r = x; dz = 1; end
        else begin d = x / y; r = x % y; lat = WIDTH + 1; end
      end
    endcase
  endtask

  // One transaction: accept, wait for result, hold under backpressure, release
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int hold);
    logic [31:0] ed, er;
    logic        edz, eil;
    int          elat, lat;
    bit          busy_ok, stable_ok;
    logic [31:0] hd, hr;
    logic        hdz, hil;
    ref_model(f, x, y, ed, er, edz, eil, elat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1; alu_func = f; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 0; a = $urandom; b = $urandom; alu_func = 3'($urandom);
    lat = 0; busy_ok = 1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready) busy_ok = 0;
    end
    check("latency", 32'(lat), 32'(elat));
    if (elat > 1) check("in_ready_busy", 32'(busy_ok), 32'd1);
    check("data_out", data_out, ed);
    check("rem_out", rem_out, er);
    check("div_zero", 32'(div_zero), 32'(edz));
    check("illegal", 32'(illegal), 32'(eil));
    // Competing request while the result waits; it must not be taken
    in_valid = 1; alu_func = ALU_ADD; a = $urandom; b = $urandom;
    hd = data_out; hr = rem_out; hdz = div_zero; hil = illegal;
    stable_ok = 1;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || in_ready || data_out !== hd || rem_out !== hr ||
          div_zero !== hdz || illegal !== hil) stable_ok = 0;
    end
    if (hold > 0) check("hold_stable", 32'(stable_ok), 32'd1);
    out_ready = 1;
    @(negedge clk);
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    out_ready = 0; in_valid = 0;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] x, y;
    bit          seen;
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; alu_func = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_rem_out", rem_out, 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    run_op(ALU_ADD, 25, 24, 0);
    run_op(ALU_SUB, 25, 24, 0);
    run_op(ALU_AND, 25, 24, 1);
    run_op(ALU_OR,  25, 24, 0);
    run_op(ALU_XOR, 25, 24, 2);
    run_op(ALU_SLT, 32'hFFFF_FFE7, 24, 0);
    run_op(ALU_SLT, 25, 32'hFFFF_FFE8, 0);
    run_op(ALU_ADD, 32'hFFFF_FFFF, 1, 0);
    run_op(ALU_MUL, 25, 24, 0);
    run_op(ALU_DIV, 25, 24, 0);
    run_op(ALU_DIV, 25, 0, 0);
    run_op(ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF1, 10);
    run_op(ALU_DIV, 32'hFFFF_FFFF, 32'h0000_0007, 3);

    // Reset during the 10th MUL iteration: the result must never appear
    @(negedge clk);
    in_valid = 1; alu_func = ALU_MUL; a = 25; b = 24;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      run_op(f, x, y, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
